// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, IO region decode
// and transfer-size clamping.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } arb_state_t;

   localparam logic [1:0] IO_REGION = 2'b11;

   function automatic logic is_io(input logic [31:0] a);
      return a[17:16] == IO_REGION;
   endfunction

   // Limits a requested log2 byte count to what one line can hold.
   function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_log2);
      return (size > max_log2) ? max_log2 : size;
   endfunction

endpackage

// File: rtl/prio_arbiter.sv
// Fixed-priority one-hot grant; the lowest-index active request wins.
module prio_arbiter #(
   parameter int NPORT = 2
) (
   input  logic [NPORT-1:0] req,
   output logic [NPORT-1:0] gnt
);

   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int p = 0; p < NPORT; p++) begin
         if (req[p] && !found) begin
            gnt[p] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port byte-serial memory arbiter: grants one requester at a time and
// walks its read or write across a byte-wide RAM / IO port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | bus quiet, waiting for an eligible request
// ST_READ  | issuing addresses and capturing mem_din one cycle later
// ST_WRITE | driving one byte per cycle, stalled by a full IO buffer
// ST_DONE  | one-cycle done pulse (rdata valid for reads)
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NPORT      = 2,
   parameter int LINE_BYTES = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rdy,
   input  logic [NPORT-1:0]                req,
   input  logic [NPORT-1:0]                we,
   input  logic [32*NPORT-1:0]             addr,
   input  logic [3*NPORT-1:0]              size,
   input  logic [8*LINE_BYTES*NPORT-1:0]   wdata,
   input  logic                            flush,
   input  logic [NPORT-1:0]                flush_mask,
   output logic [NPORT-1:0]                done,
   output logic [8*LINE_BYTES-1:0]         rdata,
   input  logic                            io_buffer_full,
   input  logic [7:0]                      mem_din,
   output logic [7:0]                      mem_dout,
   output logic [31:0]                     mem_a,
   output logic                            mem_wr
);

   localparam int MAXLOG = $clog2(LINE_BYTES);
   localparam int CW     = MAXLOG + 1;
   localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int LW     = 8 * LINE_BYTES;

   arb_state_t          state;
   logic [NPORT-1:0]    port_q;
   logic [31:0]         base_q;
   logic [CW-1:0]       len_q;
   logic [CW-1:0]       cnt;
   logic [LW-1:0]       wdata_q;
   logic [LW-1:0]       rbuf;
   logic [LW-1:0]       rbuf_nxt;
   logic [LW-1:0]       rdata_q;
   logic [NPORT-1:0]    done_q;

   logic [NPORT-1:0]    elig;
   logic [NPORT-1:0]    gnt;
   logic [PW-1:0]       gidx;
   logic                sel_we;
   logic [31:0]         sel_addr;
   logic [2:0]          sel_size;
   logic [LW-1:0]       sel_wdata;
   logic [CW-1:0]       sel_len;
   logic [31:0]         cur_addr;
   logic                wr_ok;
   logic                flush_hit;

   assign elig = req & ~({NPORT{flush}} & flush_mask);

   prio_arbiter #(.NPORT(NPORT)) u_prio (
      .req (elig),
      .gnt (gnt)
   );

   always_comb begin
      gidx = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (gnt[p]) gidx = PW'(p);
      end
   end

   assign sel_we    = we[gidx];
   assign sel_addr  = addr[32*gidx +: 32];
   assign sel_size  = size[3*gidx +: 3];
   assign sel_wdata = wdata[LW*gidx +: LW];
   assign sel_len   = CW'(1) << clamp_size(sel_size, 3'(MAXLOG));

   assign cur_addr  = base_q + 32'(cnt);
   assign wr_ok     = (state == ST_WRITE) && rdy && !(is_io(cur_addr) && io_buffer_full);
   assign flush_hit = flush && |(flush_mask & port_q);

   // Byte cnt-1 arrives on mem_din this cycle (address was driven last cycle).
   always_comb begin
      rbuf_nxt = rbuf;
      if (cnt != '0) rbuf_nxt[8*(cnt - CW'(1)) +: 8] = mem_din;
   end

   // While frozen mid-read, keep presenting the address whose data is still
   // owed, so mem_din is correct again in the first cycle rdy returns.
   always_comb begin
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      unique case (state)
         ST_READ: begin
            if (!rdy && cnt != '0) mem_a = cur_addr - 32'd1;
            else if (cnt < len_q)  mem_a = cur_addr;
         end
         ST_WRITE: begin
            mem_a    = cur_addr;
            mem_dout = wdata_q[8*cnt +: 8];
            mem_wr   = wr_ok;
         end
         default: ;
      endcase
   end

   assign done  = done_q & {NPORT{rdy}};
   assign rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         port_q  <= '0;
         base_q  <= '0;
         len_q   <= '0;
         cnt     <= '0;
         wdata_q <= '0;
         rbuf    <= '0;
         rdata_q <= '0;
         done_q  <= '0;
      end else if (rdy) begin
         done_q <= '0;
         unique case (state)
            ST_IDLE: begin
               rdata_q <= '0;
               if (|gnt) begin
                  port_q  <= gnt;
                  base_q  <= sel_addr;
                  len_q   <= sel_len;
                  wdata_q <= sel_wdata;
                  rbuf    <= '0;
                  cnt     <= '0;
                  state   <= sel_we ? ST_WRITE : ST_READ;
               end
            end
            ST_READ: begin
               if (flush_hit) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  if (cnt != '0) rbuf <= rbuf_nxt;
                  if (cnt == len_q) begin
                     rdata_q <= rbuf_nxt;
                     done_q  <= port_q;
                     cnt     <= '0;
                     state   <= ST_DONE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ST_WRITE: begin
               if (wr_ok) begin
                  if (cnt == len_q - CW'(1)) begin
                     done_q <= port_q;
                     cnt    <= '0;
                     state  <= ST_DONE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ST_DONE: begin
               rdata_q <= '0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NPORT=2, LINE_BYTES=4) with a byte RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [63:0] addr;
   logic [5:0]  size;
   logic [63:0] wdata;
   logic        flush;
   logic [1:0]  flush_mask;
   logic [1:0]  done;
   logic [31:0] rdata;
   logic        io_buffer_full;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   logic [7:0]  mem [256];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ea;
   logic [31:0] wexp;

   always #5 clk = ~clk;

   always @(posedge clk) mem_din <= mem[mem_a[7:0]];

   mem_arbiter #(.NPORT(2), .LINE_BYTES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .req            (req),
      .we             (we),
      .addr           (addr),
      .size           (size),
      .wdata          (wdata),
      .flush          (flush),
      .flush_mask     (flush_mask),
      .done           (done),
      .rdata          (rdata),
      .io_buffer_full (io_buffer_full),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic gap();
      req = 2'b00; we = 2'b00; flush = 1'b0; flush_mask = 2'b00;
      io_buffer_full = 1'b0; rdy = 1'b1; rst = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; req = '0; we = '0; addr = '0; size = '0; wdata = '0;
      flush = 1'b0; flush_mask = '0; io_buffer_full = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
      mem[8'h10] = 8'hA5; mem[8'h20] = 8'h5C; mem[8'hFE] = 8'h77; mem[8'hFF] = 8'h88;

      // reset state
      step(); settle();
      chk("rst_done", done, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_mem_dout", mem_dout, 8'h00);
      step(); rst = 1'b0; settle();

      // port 1 read, 4 bytes at 0x100
      step(); req = 2'b10; we = 2'b00; addr[63:32] = 32'h100; size[5:3] = 3'd2; settle();
      chk("s1_t0_mem_a", mem_a, 32'h0);
      for (int c = 1; c <= 7; c++) begin
         step(); if (c == 7) req = 2'b00; settle();
         ea = 32'h100 + 32'(c - 1);
         if (c <= 4) chk("s1_mem_a", mem_a, ea);
         chk("s1_done", done, (c == 6) ? 2'b10 : 2'b00);
         if (c == 6) chk("s1_rdata", rdata, 32'h44332211);
      end
      gap();

      // simultaneous requests, port 0 first
      step(); req = 2'b11; we = 2'b00; addr = {32'h20, 32'h10}; size = {3'd0, 3'd0}; settle();
      for (int c = 1; c <= 8; c++) begin
         step(); if (c == 4) req = 2'b10; if (c == 8) req = 2'b00; settle();
         if (c == 1) chk("s2_mem_a_p0", mem_a, 32'h10);
         if (c == 3) chk("s2_rdata_p0", rdata, 32'h000000A5);
         if (c == 4) chk("s2_idle_mem_a", mem_a, 32'h0);
         if (c == 5) chk("s2_mem_a_p1", mem_a, 32'h20);
         if (c == 7) chk("s2_rdata_p1", rdata, 32'h0000005C);
         chk("s2_done", done, (c == 3) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00);
      end
      gap();

      // IO write stalled by a full buffer
      step(); req = 2'b01; we = 2'b01; addr = {32'h0, 32'h30000}; size = '0; wdata = {32'h0, 32'h41};
      settle();
      for (int c = 1; c <= 6; c++) begin
         step(); io_buffer_full = (c <= 3); if (c == 6) req = 2'b00; settle();
         chk("s3_mem_wr", mem_wr, (c == 4));
         if (c == 4) chk("s3_mem_dout", mem_dout, 8'h41);
         if (c == 4) chk("s3_mem_a", mem_a, 32'h30000);
         chk("s3_done", done, (c == 5) ? 2'b01 : 2'b00);
      end
      gap();

      // flush aborts a masked read
      step(); req = 2'b10; we = 2'b00; addr = {32'h100, 32'h0}; size = {3'd2, 3'd0}; settle();
      for (int c = 1; c <= 6; c++) begin
         step(); flush = (c == 3); flush_mask = 2'b10; if (c == 4) req = 2'b00; settle();
         if (c == 3) chk("s4a_mem_a", mem_a, 32'h102);
         if (c == 4) chk("s4a_idle_mem_a", mem_a, 32'h0);
         chk("s4a_done", done, 2'b00);
      end
      gap();

      // flush does not abort a write
      step(); req = 2'b10; we = 2'b10; addr = {32'h200, 32'h0}; size = {3'd2, 3'd0};
      wdata = {32'hDDCCBBAA, 32'h0}; wexp = 32'hDDCCBBAA; settle();
      for (int c = 1; c <= 6; c++) begin
         step(); flush = (c == 3); flush_mask = 2'b10; if (c == 6) req = 2'b00; settle();
         if (c <= 4) begin
            chk("s4b_mem_wr", mem_wr, 1'b1);
            chk("s4b_mem_dout", mem_dout, wexp[8*(c-1) +: 8]);
         end
         chk("s4b_done", done, (c == 5) ? 2'b10 : 2'b00);
      end
      gap();

      // rdy low for cycles 2-3 during a 4-byte read
      step(); req = 2'b01; we = 2'b00; addr = {32'h0, 32'h100}; size = {3'd0, 3'd2}; settle();
      for (int c = 1; c <= 9; c++) begin
         step(); rdy = !(c == 2 || c == 3); if (c == 9) req = 2'b00; settle();
         if (c == 1) chk("s5_mem_a_c1", mem_a, 32'h100);
         if (c == 2) chk("s5_mem_wr_c2", mem_wr, 1'b0);
         if (c == 4) chk("s5_mem_a_c4", mem_a, 32'h101);
         if (c == 6) chk("s5_mem_a_c6", mem_a, 32'h103);
         chk("s5_done", done, (c == 8) ? 2'b01 : 2'b00);
         if (c == 8) chk("s5_rdata", rdata, 32'h44332211);
      end
      gap();

      // reset in the middle of a write
      step(); req = 2'b01; we = 2'b01; addr = {32'h0, 32'h40}; size = {3'd0, 3'd2};
      wdata = {32'h0, 32'h04030201}; settle();
      for (int c = 1; c <= 6; c++) begin
         step(); rst = (c == 2); if (c == 3) req = 2'b00; settle();
         if (c == 2) chk("s6_mem_wr_pre", mem_wr, 1'b1);
         if (c == 3) chk("s6_mem_wr_post", mem_wr, 1'b0);
         if (c == 3) chk("s6_mem_a_post", mem_a, 32'h0);
         chk("s6_done", done, 2'b00);
      end
      gap();

      // oversize request clamps to the 4-byte line
      step(); req = 2'b01; we = 2'b00; addr = {32'h0, 32'h100}; size = {3'd0, 3'd5}; settle();
      for (int c = 1; c <= 7; c++) begin
         step(); if (c == 7) req = 2'b00; settle();
         chk("s7_done", done, (c == 6) ? 2'b01 : 2'b00);
         if (c == 6) chk("s7_rdata", rdata, 32'h44332211);
      end
      gap();

      // address wraps modulo 2^32
      step(); req = 2'b10; we = 2'b00; addr = {32'hFFFF_FFFE, 32'h0}; size = {3'd2, 3'd0}; settle();
      for (int c = 1; c <= 7; c++) begin
         step(); if (c == 7) req = 2'b00; settle();
         ea = 32'hFFFF_FFFE + 32'(c - 1);
         if (c <= 4) chk("s8_mem_a", mem_a, ea);
         if (c == 6) chk("s8_rdata", rdata, 32'h22118877);
         if (c == 6) chk("s8_done", done, 2'b10);
      end
      gap();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NPORT, default 2, number of requester channels; port 0 has highest priority.
REQ-002 Parameter LINE_BYTES, default 4, maximum bytes per transaction; power of two, 1..64.
REQ-003 clk  in  1  the single clock; reset is synchronous and active-high.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global enable; low freezes all state.
REQ-006 req  in  NPORT  per-port request, held until that port's done.
REQ-007 we  in  NPORT  per-port write flag: 1 = write, 0 = read.
REQ-008 addr  in  32*NPORT  per-port byte base address, flattened with port p at bits [32p+31:32p].
REQ-009 size  in  3*NPORT  per-port log2 byte count; values above log2(LINE_BYTES) are clamped to LINE_BYTES.
REQ-010 wdata  in  8*LINE_BYTES*NPORT  per-port write data, little-endian, byte k written to addr+k.
REQ-011 flush  in  1  abort request, qualified by flush_mask.
REQ-012 flush_mask  in  NPORT  ports affected by flush.
REQ-013 done  out  NPORT  one-cycle completion pulse for the granted port.
REQ-014 rdata  out  8*LINE_BYTES  read data, valid only while a done bit is high; bytes at or above the transfer length are 0.
REQ-015 io_buffer_full  in  1  high when the UART write buffer is full.
REQ-016 mem_din  in  8  RAM read byte; it corresponds to the mem_a driven in the previous cycle.
REQ-017 mem_dout  out  8  RAM write byte.
REQ-018 mem_a  out  32  RAM byte address.
REQ-019 mem_wr  out  1  1 = write.

Function
REQ-020 The FSM SHALL have the states IDLE, READ, WRITE and DONE, and SHALL service only one transaction at a time, without preemption.
REQ-021 In IDLE, a cycle T with any req bit set SHALL grant the lowest-index requesting port and latch that port's we, addr, size and wdata. The port is excluded if flush is high and its flush_mask bit is set.
REQ-022 For a read of n bytes, mem_a SHALL equal base+k in cycle T+1+k, for k = 0..n-1.
REQ-023 Read byte k SHALL be captured from mem_din in cycle T+2+k.
REQ-024 For a read, the FSM SHALL be in DONE in cycle T+n+2, pulsing done[p] with registered rdata.
REQ-025 For a write, mem_wr SHALL be 1 and mem_dout SHALL be byte k while mem_a = base+k, in cycles T+1..T+n.
REQ-026 For a write, done[p] SHALL pulse in cycle T+n+1.
REQ-027 DONE SHALL return to IDLE; the earliest next grant is therefore the cycle after the done pulse, and req sampled in the done cycle SHALL NOT re-grant.
REQ-028 Addresses with addr[17:16] = 2'b11 SHALL be treated as IO.
REQ-029 An IO write byte SHALL be stalled (mem_wr = 0, byte index held) while io_buffer_full = 1, resuming the cycle after it drops.
REQ-030 Address arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-031 Every write SHALL be preceded by at least one cycle with mem_wr = 0; passing through IDLE guarantees this.
REQ-032 When flush = 1 during a READ of a masked port, the FSM SHALL go to IDLE next cycle with no done pulse.
REQ-033 WRITE SHALL never be aborted; a write completes and pulses done regardless of flush.
REQ-034 When rdy = 0, all registers SHALL hold, mem_wr SHALL be 0, and no mem_din byte SHALL be captured. The interrupted byte is re-issued when rdy returns.
REQ-035 When idle, mem_a SHALL be 0, mem_wr 0 and mem_dout 0.

Reset
REQ-036 On rst = 1 at a clock edge, the block SHALL enter IDLE with done = 0, rdata = 0, mem_wr = 0, mem_a = 0, mem_dout = 0 and byte counter = 0, regardless of rdy.
REQ-037 Reset mid-transaction SHALL abandon it, with no done pulse.

Structure
REQ-038 The FSM state encoding, the IO address-region constant (2'b11 at [17:16]) and the size-clamp helper SHALL live in the shared defines package.
REQ-039 Priority selection SHALL be a sub-module, prio_arbiter (NPORT-wide fixed-priority one-hot grant, combinational).

Verification
REQ-040 Scenario: NPORT = 2, LINE_BYTES = 4; port 1 read, size 2, addr 0x100, memory holding 0x11,0x22,0x33,0x44, req in cycle 0 -> mem_a = 0x100..0x103 in cycles 1-4, done[1] in cycle 6, rdata = 0x44332211.
REQ-041 Scenario: ports 0 and 1 request in the same cycle -> port 0 is served first; port 1 is granted the cycle after done[0].
REQ-042 Scenario: port 0 write, size 0, addr 0x30000, data 0x41, with io_buffer_full high for cycles 1-3 -> mem_wr = 1 only in cycle 4, done[0] in cycle 5.
REQ-043 Scenario: port 1 read of 4 bytes with flush and flush_mask = 2'b10 in cycle 3 -> IDLE in cycle 4, done stays 0. The same flush during a port 1 write -> the write completes and done[1] pulses.
REQ-044 Scenario: rdy low for cycles 2-3 during a 4-byte read -> every byte is still captured correctly, and done is delayed by exactly 2 cycles.
REQ-045 Scenario: rst asserted mid-write -> next cycle mem_wr = 0, FSM in IDLE, no done pulse.
